// File: rtl/nibble_add_sequencer.sv
// rtl/nibble_add_sequencer.sv - multi-cycle WIDTH-bit adder using one 4-bit add-with-carry slice
module nibble_add_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int N     = WIDTH / 4;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
            $error("nibble_add_sequencer: WIDTH must be a multiple of 4 and at least 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    logic [3:0]         slice_a, slice_b, slice_s;
    logic               slice_c;
    logic               carry_into_top;

    // Slice operand mux over constant part-selects keeps every index in range for any WIDTH.
    always_comb begin
        slice_a = '0;
        slice_b = '0;
        for (int i = 0; i < N; i++) begin
            if (idx_q == IDX_W'(i)) begin
                slice_a = a_q[4*i +: 4];
                slice_b = b_q[4*i +: 4];
            end
        end
    end

    assign {slice_c, slice_s} = {1'b0, slice_a} + {1'b0, slice_b} + {4'b0000, carry_q};
    // Carry into bit 3 of the slice, recovered from the sum bit and its operands.
    assign carry_into_top = slice_a[3] ^ slice_b[3] ^ slice_s[3];

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    sum_d   = '0;
                    carry_d = cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < N; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        sum_d[4*i +: 4] = slice_s;
                    end
                end
                carry_d = slice_c;
                if (idx_q == IDX_W'(N - 1)) begin
                    cout_d  = slice_c;
                    ovf_d   = carry_into_top ^ slice_c;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            idx_q   <= idx_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_nibble_add_sequencer.sv
// tb/tb_nibble_add_sequencer.sv - self-checking bench for 16-bit and 4-bit nibble_add_sequencer instances
module tb_nibble_add_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [15:0] ia [2];
    logic [15:0] ib [2];
    logic        icin [2];
    logic        iv [2];
    logic        ordy [2];

    logic        r16, v16, b16, c16, o16;
    logic [15:0] s16;
    logic        r4, v4, b4, c4, o4;
    logic [3:0]  s4;

    logic        irdy [2];
    logic        ovld [2];
    logic        obsy [2];
    logic        ocout [2];
    logic        oovf [2];
    logic [15:0] osum [2];

    int n_cmp = 0;
    int n_bad = 0;

    nibble_add_sequencer #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(r16),
        .a(ia[0]), .b(ib[0]), .cin(icin[0]), .out_valid(v16), .out_ready(ordy[0]),
        .sum(s16), .cout(c16), .ovf(o16), .busy(b16)
    );

    nibble_add_sequencer #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(r4),
        .a(ia[1][3:0]), .b(ib[1][3:0]), .cin(icin[1]), .out_valid(v4), .out_ready(ordy[1]),
        .sum(s4), .cout(c4), .ovf(o4), .busy(b4)
    );

    assign irdy[0] = r16;  assign irdy[1] = r4;
    assign ovld[0] = v16;  assign ovld[1] = v4;
    assign obsy[0] = b16;  assign obsy[1] = b4;
    assign ocout[0] = c16; assign ocout[1] = c4;
    assign oovf[0] = o16;  assign oovf[1] = o4;
    assign osum[0] = s16;  assign osum[1] = {12'h000, s4};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int wid(input int i);
        return (i == 0) ? 16 : 4;
    endfunction

    // Reference result from plain integer arithmetic on the operand values.
    function automatic void calc(input int i, input logic [15:0] av, input logic [15:0] bv,
                                 input logic cv, output logic [15:0] s, output logic c,
                                 output logic o);
        int unsigned w, mask, aa, bb, full, lm, cm;
        w    = wid(i);
        mask = (32'd1 << w) - 1;
        aa   = 32'(av) & mask;
        bb   = 32'(bv) & mask;
        full = aa + bb + 32'(cv);
        s    = 16'(full & mask);
        c    = full[w];
        lm   = mask >> 1;
        cm   = ((aa & lm) + (bb & lm) + 32'(cv)) >> (w - 1);
        o    = cm[0] ^ c;
    endfunction

    bit          m_busy [2];
    int          m_left [2];
    bit          m_have [2];
    logic [15:0] m_sum [2], e_sum [2];
    logic        m_cout [2], e_cout [2];
    logic        m_ovf [2], e_ovf [2];

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_busy[i] = 0; m_left[i] = 0; m_have[i] = 1;
                m_sum[i] = '0; m_cout[i] = 1'b0; m_ovf[i] = 1'b0;
            end else if (!m_busy[i]) begin
                if (iv[i]) begin
                    calc(i, ia[i], ib[i], icin[i], e_sum[i], e_cout[i], e_ovf[i]);
                    m_busy[i] = 1;
                    m_left[i] = wid(i) / 4;
                    m_have[i] = 0;
                end
            end else if (m_left[i] > 0) begin
                m_left[i]--;
                if (m_left[i] == 0) begin
                    m_sum[i] = e_sum[i]; m_cout[i] = e_cout[i]; m_ovf[i] = e_ovf[i];
                    m_have[i] = 1;
                end
            end else if (ordy[i]) begin
                m_busy[i] = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("in_ready[%0d]", i), 32'(irdy[i]), 32'(!m_busy[i]));
                chk($sformatf("out_valid[%0d]", i), 32'(ovld[i]), 32'(m_busy[i] && m_left[i] == 0));
                chk($sformatf("busy[%0d]", i), 32'(obsy[i]), 32'(m_busy[i]));
                if (m_have[i]) begin
                    chk($sformatf("sum[%0d]", i), 32'(osum[i]), 32'(m_sum[i]));
                    chk($sformatf("cout[%0d]", i), 32'(ocout[i]), 32'(m_cout[i]));
                    chk($sformatf("ovf[%0d]", i), 32'(oovf[i]), 32'(m_ovf[i]));
                end
            end
        end
    end

    task automatic run(input int i, input logic [15:0] av, input logic [15:0] bv, input logic cv,
                       input logic [15:0] xs, input logic xc, input logic xo, input int xlat);
        int lat;
        @(negedge clk);
        ia[i] = av; ib[i] = bv; icin[i] = cv; iv[i] = 1'b1; ordy[i] = 1'b1;
        @(negedge clk);
        iv[i] = 1'b0; ia[i] = 16'($urandom); ib[i] = 16'($urandom); icin[i] = 1'($urandom);
        lat = 0;
        do begin
            @(posedge clk); lat++; @(negedge clk);
        end while (!ovld[i] && lat < 20);
        chk("latency", 32'(lat), 32'(xlat));
        chk("lit_sum", 32'(osum[i]), 32'(xs));
        chk("lit_cout", 32'(ocout[i]), 32'(xc));
        chk("lit_ovf", 32'(oovf[i]), 32'(xo));
    endtask

    initial begin
        int lat;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ia[i] = '0; ib[i] = '0; icin[i] = 1'b0; ordy[i] = 1'b0;
            iv[i] = 1'b1;
        end
        ia[0] = 16'hABCD;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(r16), 32'd1);
        chk("rst_out_valid", 32'(v16), 32'd0);
        chk("rst_busy", 32'(b16), 32'd0);
        chk("rst_sum", 32'(s16), 32'd0);
        chk("rst_busy4", 32'(b4), 32'd0);
        iv[0] = 1'b0; iv[1] = 1'b0;
        rst_n = 1'b1;

        run(0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 4);
        run(0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 4);
        run(0, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1, 4);

        @(negedge clk);
        ia[0] = 16'h1234; ib[0] = 16'h4321; icin[0] = 1'b1; iv[0] = 1'b1; ordy[0] = 1'b0;
        @(negedge clk);
        iv[0] = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); lat++; @(negedge clk);
        end while (!v16 && lat < 20);
        chk("bp_latency", 32'(lat), 32'd4);
        iv[0] = 1'b1; ia[0] = 16'hFFFF;
        repeat (5) begin
            @(posedge clk); @(negedge clk);
            chk("bp_out_valid", 32'(v16), 32'd1);
            chk("bp_sum", 32'(s16), 32'h5556);
            chk("bp_in_ready", 32'(r16), 32'd0);
        end
        iv[0] = 1'b0; ordy[0] = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("bp_release_ready", 32'(r16), 32'd1);
        chk("bp_release_valid", 32'(v16), 32'd0);
        run(0, 16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1, 1'b0, 4);

        run(1, 16'h000F, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1);
        run(1, 16'h0006, 16'h0005, 1'b0, 16'h000B, 1'b0, 1'b1, 1);

        @(negedge clk);
        ia[0] = 16'h1111; ib[0] = 16'h1111; icin[0] = 1'b0; iv[0] = 1'b1; ordy[0] = 1'b1;
        @(negedge clk);
        iv[0] = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(v16), 32'd0);
        chk("arst_busy", 32'(b16), 32'd0);
        chk("arst_in_ready", 32'(r16), 32'd1);
        chk("arst_sum", 32'(s16), 32'd0);
        chk("arst_cout", 32'(c16), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            chk("arst_no_stale", 32'(v16), 32'd0);
        end

        repeat (3000) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                iv[i]   = ($urandom_range(0, 2) != 0);
                ia[i]   = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
                ib[i]   = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
                icin[i] = 1'($urandom);
                ordy[i] = ($urandom_range(0, 3) != 0);
            end
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            iv[i] = 1'b0; ordy[i] = 1'b1;
        end
        repeat (10) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/nibble_add_sequencer.md
# nibble_add_sequencer

Multi-cycle adder controller. It accepts WIDTH-bit operand pairs over a valid/ready handshake and adds them one 4-bit slice per cycle, LSB slice first, using a single 4-bit add-with-carry slice and a registered inter-slice carry. It returns the sum, carry-out and signed overflow over a second valid/ready handshake. It is the sequencing front-end that lets the team's 4-bit ripple adder serve wide additions.

## Interface
- WIDTH, 16, operand/sum width in bits; must be a multiple of 4 and ≥4. Elaboration fails otherwise.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operand pair a/b/cin is valid
- in_ready  output  1  block can accept operands; equals (state==IDLE)
- a  input  WIDTH  operand A, unsigned or two's complement
- b  input  WIDTH  operand B
- cin  input  1  carry into slice 0
- out_valid  output  1  result valid; equals (state==DONE)
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  registered result (a+b+cin) mod 2^WIDTH
- cout  output  1  carry out of MSB slice
- ovf  output  1  signed overflow: carry into bit WIDTH-1 XOR cout
- busy  output  1  high in RUN or DONE

## Operation
- N = WIDTH/4 slices. Slice index idx is ceil(log2(N)) bits wide, minimum 1.
- States: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE: in_ready=1.
  - On in_valid&&in_ready, capture a, b and cin into operand registers.
  - Clear the sum register, set carry=cin, set idx=0, go to RUN.
- RUN: each cycle, {c,s} = a[4*idx+:4] + b[4*idx+:4] + carry.
  - sum[4*idx+:4] <= s; carry <= c.
  - For the MSB slice, also register the carry into bit WIDTH-1 for ovf.
  - If idx==N-1: cout <= c, ovf <= (carry into MSB) ^ c, go to DONE. Otherwise idx <= idx+1.
- DONE: out_valid=1. sum, cout and ovf are held stable.
  - On out_ready, go to IDLE on the next edge.
  - sum, cout and ovf keep their values in IDLE until the next capture.
- No overlap: in_ready=0 throughout RUN and DONE. in_valid in those states is ignored and must not alter any register.
- Operand registers are the only source for RUN. Changes on a/b after the capture edge have no effect.
- Arithmetic is modulo 2^WIDTH; the carry out of the MSB is reported only via cout.

## Timing
- Reset (rst_n low, asynchronous, takes effect immediately): state=IDLE.
  - sum=0, cout=0, ovf=0, out_valid=0, busy=0, idx=0, carry=0.
  - in_ready=1, but no transfer is accepted while rst_n is low.
- Reset during RUN or DONE aborts the operation. The result is discarded and never presented.
- Capture at edge k. RUN occupies edges k+1..k+N. out_valid rises after edge k+N.
  - Accept-to-result latency is N cycles: 4 for WIDTH=16, 1 for WIDTH=4.
- Result handshake completes on the edge where out_valid&&out_ready. in_ready rises after that edge.
- Maximum throughput is one operation per N+2 cycles (capture, N RUN cycles, DONE) with out_ready held high.
- out_ready high before DONE is legal and has no effect until DONE.
- sum may show partial slices during RUN. Consumers sample sum only while out_valid=1.

## Test plan
- Async reset mid-RUN: assert rst_n=0 one cycle after capture -> without a clock edge, out_valid=0, busy=0, in_ready=1, sum=0, cout=0. After release, no stale result appears.
- Cross-slice carry: a=16'h00FF, b=16'h0001, cin=0 -> out_valid exactly 4 cycles after capture; sum=16'h0100, cout=0, ovf=0.
- Full wrap: a=16'hFFFF, b=16'h0001, cin=0 -> sum=16'h0000, cout=1, ovf=0.
- Signed overflow with carry-in: a=16'h7FFF, b=16'h0000, cin=1 -> sum=16'h8000, cout=0, ovf=1.
- Backpressure: a=16'h1234, b=16'h4321, cin=1, out_ready=0 for 5 cycles -> out_valid stays 1 and sum=16'h5556 stays stable; in_ready=0; a competing in_valid with a=16'hFFFF is ignored. Raise out_ready -> IDLE next edge, then the next operand pair is accepted.
- Back-to-back with WIDTH=4 instance: a=4'hF, b=4'h1, cin=0 then a=4'h6, b=4'h5 with out_ready=1 -> sum=4'h0/cout=1, then sum=4'hB/cout=0/ovf=1, each 1 cycle after capture.
